// File: rtl/branch_pc_unit.sv
// Program counter and next-PC selection for the single-cycle RV32I core.
// Resolves branches, traps misaligned targets, and keeps committed-branch statistics.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_valid_i,
  input  logic             stall_i,
  input  logic             is_branch_i,
  input  logic             is_jal_i,
  input  logic             is_jalr_i,
  input  logic [2:0]       funct3_i,
  input  logic             br_equal_i,
  input  logic             br_less_i,
  input  logic [31:0]      target_i,
  input  logic             trap_ack_i,
  output logic             br_unsign_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             taken_o,
  output logic             trap_o,
  output logic [31:0]      trap_pc_o,
  output logic [31:0]      trap_tval_o,
  output logic [CNT_W-1:0] br_total_o,
  output logic [CNT_W-1:0] br_taken_o
);

  typedef enum logic {RUN, TRAP} state_t;

  state_t           state;
  logic [31:0]      pc;
  logic             trap;
  logic [31:0]      trap_pc;
  logic [31:0]      trap_tval;
  logic [CNT_W-1:0] br_total;
  logic [CNT_W-1:0] br_taken;

  logic        cond;
  logic        cond_valid;
  logic        branch_sel;
  logic        taken;
  logic [31:0] eff_target;
  logic        commit;
  logic        fault;

  // Jumps outrank branches, so a branch is only resolved/counted when it is the sole class.
  assign branch_sel = is_branch_i & ~is_jal_i & ~is_jalr_i;

  always_comb begin
    cond       = 1'b0;
    cond_valid = 1'b1;
    unique case (funct3_i)
      3'b000:          cond = br_equal_i;
      3'b001:          cond = ~br_equal_i;
      3'b100, 3'b110:  cond = br_less_i;
      3'b101, 3'b111:  cond = ~br_less_i;
      default:         cond_valid = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    if (is_jal_i || is_jalr_i) taken = 1'b1;
    else if (is_branch_i)      taken = cond;
  end

  assign eff_target = is_jalr_i ? {target_i[31:1], 1'b0} : target_i;
  assign commit     = (state == RUN) && instr_valid_i && !stall_i;
  assign fault      = taken && (eff_target[1:0] != 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= RUN;
      pc        <= RESET_PC;
      trap      <= 1'b0;
      trap_pc   <= '0;
      trap_tval <= '0;
      br_total  <= '0;
      br_taken  <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (commit) begin
            if (fault) begin
              state     <= TRAP;
              trap      <= 1'b1;
              trap_pc   <= pc;
              trap_tval <= eff_target;
            end else begin
              pc <= taken ? eff_target : pc + 32'd4;
              if (branch_sel && cond_valid) begin
                br_total <= br_total + CNT_W'(1);
                if (cond) br_taken <= br_taken + CNT_W'(1);
              end
            end
          end
        end
        TRAP: begin
          if (trap_ack_i) begin
            state <= RUN;
            trap  <= 1'b0;
            pc    <= TRAP_VEC;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign br_unsign_o = funct3_i[1];
  assign pc_o        = pc;
  assign pc_plus4_o  = pc + 32'd4;
  assign taken_o     = taken;
  assign trap_o      = trap;
  assign trap_pc_o   = trap_pc;
  assign trap_tval_o = trap_tval;
  assign br_total_o  = br_total;
  assign br_taken_o  = br_taken;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: a driver issues directed and random cycles against
// a reference model; a monitor pops expectations and compares DUT outputs.
module tb_branch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CNT_MOD  = 16;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             instr_valid_i, stall_i, is_branch_i, is_jal_i, is_jalr_i;
  logic [2:0]       funct3_i;
  logic             br_equal_i, br_less_i, trap_ack_i;
  logic [31:0]      target_i;
  logic             br_unsign_o, taken_o, trap_o;
  logic [31:0]      pc_o, pc_plus4_o, trap_pc_o, trap_tval_o;
  logic [CNT_W-1:0] br_total_o, br_taken_o;

  branch_pc_unit #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .instr_valid_i(instr_valid_i), .stall_i(stall_i),
    .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
    .funct3_i(funct3_i), .br_equal_i(br_equal_i), .br_less_i(br_less_i),
    .target_i(target_i), .trap_ack_i(trap_ack_i), .br_unsign_o(br_unsign_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .taken_o(taken_o), .trap_o(trap_o),
    .trap_pc_o(trap_pc_o), .trap_tval_o(trap_tval_o),
    .br_total_o(br_total_o), .br_taken_o(br_taken_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic        unsign;
    logic [31:0] plus4;
    logic [31:0] pc;
    logic        trap;
    logic [31:0] tpc;
    logic [31:0] tval;
    int unsigned total;
    int unsigned btaken;
  } exp_t;

  exp_t q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  longint unsigned m_pc;
  bit              m_trap;
  longint unsigned m_tpc, m_tval;
  int unsigned     m_total, m_btaken;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_trap = 0; m_tpc = 0; m_tval = 0; m_total = 0; m_btaken = 0;
  endtask

  // Drive one cycle, then predict combinational and post-edge values.
  task automatic apply(input bit v, input bit s, input bit br, input bit jal, input bit jalr,
                       input bit [2:0] f3, input bit eq, input bit lt,
                       input bit [31:0] tgt, input bit ack);
    exp_t e;
    bit tk, is_cond, valid_f3;
    longint unsigned dest;
    @(negedge clk);
    instr_valid_i = v; stall_i = s; is_branch_i = br; is_jal_i = jal; is_jalr_i = jalr;
    funct3_i = f3; br_equal_i = eq; br_less_i = lt; target_i = tgt; trap_ack_i = ack;
    #1;
    is_cond = br && !jal && !jalr;
    valid_f3 = 1;
    case (f3)
      3'd0: tk = eq;          // BEQ
      3'd1: tk = !eq;         // BNE
      3'd4, 3'd6: tk = lt;    // BLT / BLTU
      3'd5, 3'd7: tk = !lt;   // BGE / BGEU
      default: begin tk = 0; valid_f3 = 0; end
    endcase
    if (jal || jalr) tk = 1;
    else if (!br) tk = 0;
    e.taken  = tk;
    e.unsign = f3[1];
    e.plus4  = 32'((m_pc + 4) % 64'h1_0000_0000);
    dest = jalr ? (tgt / 2) * 2 : tgt;
    if (!m_trap) begin
      if (v && !s) begin
        if (tk && (dest % 4) != 0) begin
          m_trap = 1; m_tpc = m_pc; m_tval = dest;
        end else begin
          m_pc = tk ? dest : (m_pc + 4) % 64'h1_0000_0000;
          if (is_cond && valid_f3) begin
            m_total = (m_total + 1) % CNT_MOD;
            if (tk) m_btaken = (m_btaken + 1) % CNT_MOD;
          end
        end
      end
    end else if (ack) begin
      m_pc = TRAP_VEC; m_trap = 0;
    end
    e.pc = 32'(m_pc); e.trap = m_trap; e.tpc = 32'(m_tpc); e.tval = 32'(m_tval);
    e.total = m_total; e.btaken = m_btaken;
    q.push_back(e);
  endtask

  task automatic plain();
    apply(1, 0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    instr_valid_i = 0; stall_i = 0; is_branch_i = 0; is_jal_i = 0; is_jalr_i = 0;
    trap_ack_i = 0;
    model_reset();
    #1;
    chk("rst_pc", pc_o, RESET_PC);
    chk("rst_trap", {31'd0, trap_o}, 32'd0);
    chk("rst_tpc", trap_pc_o, 32'd0);
    chk("rst_tval", trap_tval_o, 32'd0);
    chk("rst_total", {28'd0, br_total_o}, 32'd0);
    chk("rst_btaken", {28'd0, br_taken_o}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Monitor: combinational outputs late in the cycle, registered state just after the edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        r = q.pop_front();
        chk("taken_o", {31'd0, taken_o}, {31'd0, r.taken});
        chk("br_unsign_o", {31'd0, br_unsign_o}, {31'd0, r.unsign});
        chk("pc_plus4_o", pc_plus4_o, r.plus4);
        @(posedge clk);
        #1;
        chk("pc_o", pc_o, r.pc);
        chk("trap_o", {31'd0, trap_o}, {31'd0, r.trap});
        chk("trap_pc_o", trap_pc_o, r.tpc);
        chk("trap_tval_o", trap_tval_o, r.tval);
        chk("br_total_o", {28'd0, br_total_o}, r.total);
        chk("br_taken_o", {28'd0, br_taken_o}, r.btaken);
      end
    end
  end

  initial begin
    bit [31:0] rt;
    rst_ni = 1'b0;
    instr_valid_i = 0; stall_i = 0; is_branch_i = 0; is_jal_i = 0; is_jalr_i = 0;
    funct3_i = 0; br_equal_i = 0; br_less_i = 0; target_i = 0; trap_ack_i = 0;
    do_reset();
    plain(); plain(); plain();
    do_reset();
    repeat (4) plain();                                   // pc 0x10
    apply(1, 0, 1, 0, 0, 3'b100, 0, 1, 32'h40, 0);        // BLT taken
    apply(1, 0, 1, 0, 0, 3'b111, 0, 1, 32'h80, 0);        // BGEU not taken
    apply(1, 0, 0, 0, 1, 3'b000, 0, 0, 32'h103, 0);       // JALR misaligned
    repeat (5) apply(1, 0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 0);
    apply(1, 0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 1);           // ack
    repeat (3) apply(1, 1, 1, 0, 0, 3'b000, 1, 0, 32'h200, 0);
    apply(1, 0, 1, 0, 0, 3'b000, 1, 0, 32'h200, 0);
    apply(1, 0, 1, 0, 0, 3'b010, 1, 1, 32'h300, 0);       // reserved funct3
    apply(1, 0, 0, 1, 0, 3'd0, 0, 0, 32'hFFFF_FFFC, 0);
    plain();                                              // wraps to 0
    apply(1, 0, 0, 1, 0, 3'd0, 0, 0, 32'h8, 0);
    apply(1, 0, 0, 1, 0, 3'd0, 0, 0, 32'h8, 0);
    apply(1, 0, 0, 1, 0, 3'd0, 0, 0, 32'h2, 0);           // JAL misaligned
    apply(0, 0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 0);
    do_reset();                                           // reset mid-trap
    for (int i = 0; i < 16; i++) apply(1, 0, 1, 0, 0, 3'b001, 0, 0, 32'h40, 0);
    for (int i = 0; i < 1500; i++) begin
      rt = $urandom();
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      apply($urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rt, $urandom_range(0, 2) == 0);
      if (i == 700) begin
        apply(1, 1, 0, 0, 0, 3'd0, 0, 0, 32'h0, 0);
        do_reset();                                       // reset mid-stall
      end
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
